// File: rtl/mips_ctrl_pkg.sv
// Shared control encoding for the MIPS decode/control stage: bus bit positions,
// opcode/funct values, ALU codes, FSM states and the decoded control record.
package mips_ctrl_pkg;

  localparam int EX_ALU_SRC_BIT    = 4;
  localparam int EX_REG_DST_BIT    = 5;
  localparam int EX_SHAMT_BIT      = 6;
  localparam int MEM_WRITE_BIT     = 0;
  localparam int MEM_READ_BIT      = 1;
  localparam int MEM_BRANCH_BIT    = 2;
  localparam int WB_MEM_TO_REG_BIT = 0;
  localparam int WB_REG_WRITE_BIT  = 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_INV  = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic [3:0] alu_code;
    logic       alu_src;
    logic       reg_dst;
    logic       shamt_flag;
    logic       mem_write;
    logic       mem_read;
    logic       branch_flag;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // Unknown instructions decode to the invalid ALU code with every other control bit low.
  function automatic ctrl_t ctrl_invalid();
    ctrl_t c;
    c          = '0;
    c.alu_code = ALU_INV;
    return c;
  endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Handshake/bus bundle between the IF/ID side and the decode control stage.
interface decode_ctrl_stage_if #(
  parameter int EXEC_BUS_WIDTH = 7,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int REG_ADDR_WIDTH = 5
);
  logic [31:0]               instr;
  logic                      instr_valid;
  logic                      flush;
  logic                      stall_out;
  logic [EXEC_BUS_WIDTH-1:0] execute_bus;
  logic [MEM_BUS_WIDTH-1:0]  memory_bus;
  logic [WB_BUS_WIDTH-1:0]   wb_bus;
  logic [REG_ADDR_WIDTH-1:0] rs_out;
  logic [REG_ADDR_WIDTH-1:0] rt_out;
  logic [REG_ADDR_WIDTH-1:0] rd_out;
  logic                      valid_out;
  logic                      halted;

  modport master (
    output instr, instr_valid, flush,
    input  stall_out, execute_bus, memory_bus, wb_bus,
           rs_out, rt_out, rd_out, valid_out, halted
  );

  modport slave (
    input  instr, instr_valid, flush,
    output stall_out, execute_bus, memory_bus, wb_bus,
           rs_out, rt_out, rd_out, valid_out, halted
  );
endinterface

// File: rtl/ctrl_decode_table.sv
// Purely combinational opcode/funct to control-record decode.
module ctrl_decode_table
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  function automatic ctrl_t rtype(input logic [3:0] alu, input logic shamt, input logic write);
    ctrl_t c;
    c            = '0;
    c.alu_code   = alu;
    c.reg_dst    = 1'b1;
    c.shamt_flag = shamt;
    c.reg_write  = write;
    return c;
  endfunction

  function automatic ctrl_t itype(input logic [3:0] alu);
    ctrl_t c;
    c           = '0;
    c.alu_code  = alu;
    c.alu_src   = 1'b1;
    c.reg_write = 1'b1;
    return c;
  endfunction

  logic not_nop;

  always_comb begin
    // An all-zero word is the canonical NOP (SLL $0) and must never write back.
    not_nop = |instr;
    ctrl    = ctrl_invalid();
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_SLL:           ctrl = rtype(ALU_SLL, 1'b1, not_nop);
          FN_SRL:           ctrl = rtype(ALU_SRL, 1'b1, not_nop);
          FN_SRA:           ctrl = rtype(ALU_SRA, 1'b1, not_nop);
          FN_JR, FN_JALR: begin
            ctrl             = rtype(ALU_ADD, 1'b0, 1'b0);
            ctrl.branch_flag = 1'b1;
          end
          FN_ADD, FN_ADDU:  ctrl = rtype(ALU_ADD, 1'b0, not_nop);
          FN_SUB, FN_SUBU:  ctrl = rtype(ALU_SUB, 1'b0, not_nop);
          FN_AND:           ctrl = rtype(ALU_AND, 1'b0, not_nop);
          FN_OR:            ctrl = rtype(ALU_OR, 1'b0, not_nop);
          FN_XOR:           ctrl = rtype(ALU_XOR, 1'b0, not_nop);
          FN_NOR:           ctrl = rtype(ALU_NOR, 1'b0, not_nop);
          FN_SLT:           ctrl = rtype(ALU_SLT, 1'b0, not_nop);
          FN_SLTU:          ctrl = rtype(ALU_SLTU, 1'b0, not_nop);
          default:          ctrl = ctrl_invalid();
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl            = itype(ALU_ADD);
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl           = itype(ALU_ADD);
        ctrl.reg_write = 1'b0;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl             = '0;
        ctrl.alu_code    = ALU_SUB;
        ctrl.branch_flag = 1'b1;
      end
      OP_J, OP_JAL: begin
        ctrl             = '0;
        ctrl.alu_code    = ALU_ADD;
        ctrl.branch_flag = 1'b1;
      end
      OP_ADDI, OP_ADDIU: ctrl = itype(ALU_ADD);
      OP_SLTI:           ctrl = itype(ALU_SLT);
      OP_SLTIU:          ctrl = itype(ALU_SLTU);
      OP_ANDI:           ctrl = itype(ALU_AND);
      OP_ORI:            ctrl = itype(ALU_OR);
      OP_XORI:           ctrl = itype(ALU_XOR);
      OP_LUI:            ctrl = itype(ALU_LUI);
      default:           ctrl = ctrl_invalid();
    endcase
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// ID/EX control register with load-use stall, flush squash and HALT drain FSM.
// Load-use detection is built only when HAZARD_DETECT_EN is defined.
module decode_ctrl_stage
  import mips_ctrl_pkg::*;
#(
  parameter int EXEC_BUS_WIDTH = 7,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DRAIN_CYCLES   = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  decode_ctrl_stage_if.slave  ctrl_if
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_t                     dec;
  ctrl_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [EXEC_BUS_WIDTH-1:0] exec_q, exec_d;
  logic [MEM_BUS_WIDTH-1:0]  mem_q, mem_d;
  logic [WB_BUS_WIDTH-1:0]   wb_q, wb_d;
  logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic                      valid_q, valid_d;
  logic                      halted_q, halted_d;
  logic                      hazard, in_run, is_halt, take_halt, load_instr;

  ctrl_decode_table u_decode_table (
    .instr (ctrl_if.instr),
    .ctrl  (dec)
  );

  always_comb begin
    in_run  = (state_q == ST_RUN);
    is_halt = (ctrl_if.instr[31:26] == OP_HALT);
    hazard  = 1'b0;
`ifdef HAZARD_DETECT_EN
    hazard = in_run && ctrl_if.instr_valid && valid_q && mem_q[MEM_READ_BIT] &&
             (rt_q != '0) &&
             ((rt_q == REG_ADDR_WIDTH'(ctrl_if.instr[25:21])) ||
              (rt_q == REG_ADDR_WIDTH'(ctrl_if.instr[20:16])));
`endif
    // A HALT held behind a load-use stall is only accepted once the stall has cleared.
    take_halt  = in_run && ctrl_if.instr_valid && !ctrl_if.flush && !hazard && is_halt;
    load_instr = in_run && ctrl_if.instr_valid && !ctrl_if.flush && !hazard && !is_halt;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (take_halt) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase

    exec_d  = '0;
    mem_d   = '0;
    wb_d    = '0;
    rs_d    = '0;
    rt_d    = '0;
    rd_d    = '0;
    valid_d = 1'b0;
    if (load_instr) begin
      exec_d[3:0]               = dec.alu_code;
      exec_d[EX_ALU_SRC_BIT]    = dec.alu_src;
      exec_d[EX_REG_DST_BIT]    = dec.reg_dst;
      exec_d[EX_SHAMT_BIT]      = dec.shamt_flag;
      mem_d[MEM_WRITE_BIT]      = dec.mem_write;
      mem_d[MEM_READ_BIT]       = dec.mem_read;
      mem_d[MEM_BRANCH_BIT]     = dec.branch_flag;
      wb_d[WB_MEM_TO_REG_BIT]   = dec.mem_to_reg;
      wb_d[WB_REG_WRITE_BIT]    = dec.reg_write;
      rs_d                      = REG_ADDR_WIDTH'(ctrl_if.instr[25:21]);
      rt_d                      = REG_ADDR_WIDTH'(ctrl_if.instr[20:16]);
      rd_d                      = REG_ADDR_WIDTH'(ctrl_if.instr[15:11]);
      valid_d                   = 1'b1;
    end
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      exec_q   <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exec_q   <= exec_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign ctrl_if.stall_out   = rst_n && (!in_run || (hazard && !ctrl_if.flush));
  assign ctrl_if.execute_bus = exec_q;
  assign ctrl_if.memory_bus  = mem_q;
  assign ctrl_if.wb_bus      = wb_q;
  assign ctrl_if.rs_out      = rs_q;
  assign ctrl_if.rt_out      = rt_q;
  assign ctrl_if.rd_out      = rd_q;
  assign ctrl_if.valid_out   = valid_q;
  assign ctrl_if.halted      = halted_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Randomised bench for decode_ctrl_stage against an instruction-level reference model,
// plus directed literal checks of the key scenarios.
module tb_decode_ctrl_stage;

  localparam int DRAIN = 3;
`ifdef HAZARD_DETECT_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_ctrl_stage_if bus ();

  decode_ctrl_stage #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (bus)
  );

  // Reference model state: what the ID/EX slot should hold, and the halt progress.
  logic [6:0] m_exec;
  logic [2:0] m_mem;
  logic [1:0] m_wb;
  logic [4:0] m_rs, m_rt, m_rd;
  logic       m_valid;
  bit         m_draining, m_halted;
  int         drain_left;
  logic       m_stall, obs_stall;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control word from the instruction-set rules: {reg_write,mem_to_reg, branch,mem_read,mem_write, shamt,reg_dst,alu_src, alu[3:0]}
  function automatic logic [11:0] model_ctrl(input logic [31:0] i);
    logic [5:0] op, fn;
    logic [3:0] alu;
    logic src, dst, sh, mw, mr, br, m2r, rw;
    op = i[31:26];
    fn = i[5:0];
    alu = 4'b1111; src = 0; dst = 0; sh = 0; mw = 0; mr = 0; br = 0; m2r = 0; rw = 0;
    if (op == 6'h00) begin
      dst = 1; rw = (i != 32'd0);
      case (fn)
        6'h00: begin alu = 4'b1000; sh = 1; end
        6'h02: begin alu = 4'b1001; sh = 1; end
        6'h03: begin alu = 4'b1010; sh = 1; end
        6'h08, 6'h09: begin alu = 4'b0011; rw = 0; br = 1; end
        6'h20, 6'h21: alu = 4'b0011;
        6'h22, 6'h23: alu = 4'b0100;
        6'h24: alu = 4'b0000;
        6'h25: alu = 4'b0001;
        6'h26: alu = 4'b0010;
        6'h27: alu = 4'b0101;
        6'h2A: alu = 4'b0110;
        6'h2B: alu = 4'b0111;
        default: begin dst = 0; rw = 0; end
      endcase
    end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      alu = 4'b0011; src = 1; mr = 1; m2r = 1; rw = 1;
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
      alu = 4'b0011; src = 1; mw = 1;
    end else if (op inside {6'h04, 6'h05}) begin
      alu = 4'b0100; br = 1;
    end else if (op inside {6'h02, 6'h03}) begin
      alu = 4'b0011; br = 1;
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      src = 1; rw = 1;
      case (op)
        6'h08, 6'h09: alu = 4'b0011;
        6'h0A: alu = 4'b0110;
        6'h0B: alu = 4'b0111;
        6'h0C: alu = 4'b0000;
        6'h0D: alu = 4'b0001;
        6'h0E: alu = 4'b0010;
        default: alu = 4'b1011;
      endcase
    end
    return {rw, m2r, br, mr, mw, sh, dst, src, alu};
  endfunction

  function automatic bit model_hazard();
    return HAZ_EN && !m_draining && !m_halted && bus.instr_valid && m_valid && m_mem[1] &&
           (m_rt != 5'd0) && ((m_rt == bus.instr[25:21]) || (m_rt == bus.instr[20:16]));
  endfunction

  task automatic set_bubble();
    m_exec = '0; m_mem = '0; m_wb = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_valid = 1'b0;
  endtask

  task automatic model_edge(input bit haz);
    logic [11:0] c;
    if (!rst_n) begin
      set_bubble();
      m_draining = 0; m_halted = 0; drain_left = 0;
    end else if (m_halted) begin
      set_bubble();
    end else if (m_draining) begin
      set_bubble();
      drain_left--;
      if (drain_left == 0) begin m_draining = 0; m_halted = 1; end
    end else if (!bus.instr_valid || bus.flush || haz) begin
      set_bubble();
    end else if (bus.instr[31:26] == 6'h3F) begin
      set_bubble();
      m_draining = 1; drain_left = DRAIN;
    end else begin
      c = model_ctrl(bus.instr);
      m_exec = c[6:0]; m_mem = c[9:7]; m_wb = c[11:10];
      m_rs = bus.instr[25:21]; m_rt = bus.instr[20:16]; m_rd = bus.instr[15:11];
      m_valid = 1'b1;
    end
  endtask

  task automatic checkOutput();
    check("execute_bus", 32'(bus.execute_bus), 32'(m_exec));
    check("memory_bus", 32'(bus.memory_bus), 32'(m_mem));
    check("wb_bus", 32'(bus.wb_bus), 32'(m_wb));
    check("rs_out", 32'(bus.rs_out), 32'(m_rs));
    check("rt_out", 32'(bus.rt_out), 32'(m_rt));
    check("rd_out", 32'(bus.rd_out), 32'(m_rd));
    check("valid_out", 32'(bus.valid_out), 32'(m_valid));
    check("halted", 32'(bus.halted), 32'(m_halted));
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic v, input logic f, input logic r);
    bit haz;
    @(negedge clk);
    bus.instr = i; bus.instr_valid = v; bus.flush = f; rst_n = r;
    #1;
    haz = model_hazard();
    m_stall = !rst_n ? 1'b0 : (m_draining || m_halted) ? 1'b1 : (haz && !bus.flush);
    obs_stall = bus.stall_out;
    check("stall_out", 32'(obs_stall), 32'(m_stall));
    model_edge(haz);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] functs [16];
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    int sel;
    functs = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
               6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3E};
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 31));
    sel = $urandom_range(0, 99);
    if (sel < 2) return 32'h0;
    if (sel < 4) return {6'h3F, rs, rt, 16'h0};
    if (sel < 34) return {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), functs[$urandom_range(0, 15)]};
    case ($urandom_range(0, 13))
      0, 1: op = 6'h23;
      2: op = 6'h20;
      3: op = 6'h2B;
      4: op = 6'h28;
      5: op = 6'h04;
      6: op = 6'h05;
      7: op = 6'h02;
      8: op = 6'h03;
      9: op = 6'h08;
      10: op = 6'h0D;
      11: op = 6'h0F;
      12: op = 6'h0A;
      default: op = 6'($urandom_range(0, 63));
    endcase
    return {op, rs, rt, 16'($urandom)};
  endfunction

  localparam logic [31:0] ADDU_R3 = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
  localparam logic [31:0] LW_R5   = {6'h23, 5'd1, 5'd5, 16'd4};
  localparam logic [31:0] ADDU_S5 = {6'h00, 5'd5, 5'd2, 5'd3, 5'd0, 6'h21};
  localparam logic [31:0] LW_R0   = {6'h23, 5'd1, 5'd0, 16'd8};
  localparam logic [31:0] ADDU_S0 = {6'h00, 5'd0, 5'd2, 5'd3, 5'd0, 6'h21};
  localparam logic [31:0] BEQ_S5  = {6'h04, 5'd5, 5'd6, 16'd2};
  localparam logic [31:0] HALT    = {6'h3F, 26'd0};

  initial begin
    logic [31:0] cur_instr;
    logic cur_valid, cur_flush, cur_rst;
    int halt_cnt;
    bus.instr = '0; bus.instr_valid = 1'b0; bus.flush = 1'b0;
    set_bubble();
    m_draining = 0; m_halted = 0; drain_left = 0; m_stall = 0;

    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    check("reset_valid", 32'(bus.valid_out), 32'd0);
    check("reset_halted", 32'(bus.halted), 32'd0);
    check("reset_exec", 32'(bus.execute_bus), 32'd0);

    applyStimulus(ADDU_R3, 1'b1, 1'b0, 1'b1);
    check("addu_alu", 32'(bus.execute_bus[3:0]), 32'b0011);
    check("addu_reg_dst", 32'(bus.execute_bus[5]), 32'd1);
    check("addu_reg_write", 32'(bus.wb_bus[1]), 32'd1);
    check("addu_rd", 32'(bus.rd_out), 32'd3);
    check("addu_valid", 32'(bus.valid_out), 32'd1);

    applyStimulus(LW_R5, 1'b1, 1'b0, 1'b1);
    applyStimulus(ADDU_S5, 1'b1, 1'b0, 1'b1);
    check("loaduse_stall", 32'(obs_stall), 32'(HAZ_EN));
    check("loaduse_bubble_valid", 32'(bus.valid_out), 32'(!HAZ_EN));
    applyStimulus(ADDU_S5, 1'b1, 1'b0, 1'b1);
    check("loaduse_release_stall", 32'(obs_stall), 32'd0);
    check("loaduse_release_valid", 32'(bus.valid_out), 32'd1);

    applyStimulus(LW_R0, 1'b1, 1'b0, 1'b1);
    applyStimulus(ADDU_S0, 1'b1, 1'b0, 1'b1);
    check("r0_no_stall", 32'(obs_stall), 32'd0);

    applyStimulus(LW_R5, 1'b1, 1'b0, 1'b1);
    applyStimulus(BEQ_S5, 1'b1, 1'b1, 1'b1);
    check("flush_stall", 32'(obs_stall), 32'd0);
    check("flush_valid", 32'(bus.valid_out), 32'd0);

    applyStimulus(32'h0, 1'b1, 1'b0, 1'b1);
    check("nop_reg_write", 32'(bus.wb_bus[1]), 32'd0);
    check("nop_valid", 32'(bus.valid_out), 32'd1);

    applyStimulus(ADDU_R3, 1'b1, 1'b0, 1'b0);
    check("midreset_valid", 32'(bus.valid_out), 32'd0);
    check("midreset_exec", 32'(bus.execute_bus), 32'd0);

    applyStimulus(HALT, 1'b1, 1'b0, 1'b1);
    check("halt_edge1_stall", 32'(obs_stall), 32'd0);
    check("halt_edge1_halted", 32'(bus.halted), 32'd0);
    for (int k = 1; k <= DRAIN; k++) begin
      applyStimulus(ADDU_R3, 1'b1, 1'b0, 1'b1);
      check("drain_stall", 32'(obs_stall), 32'd1);
      check("drain_halted", 32'(bus.halted), 32'(k == DRAIN));
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(ADDU_R3, 1'b1, 1'b0, 1'b1);
      check("halted_hold", 32'(bus.halted), 32'd1);
    end
    applyStimulus(ADDU_R3, 1'b1, 1'b0, 1'b0);
    check("halt_reset_stall", 32'(obs_stall), 32'd0);
    check("halt_reset_halted", 32'(bus.halted), 32'd0);
    applyStimulus(ADDU_R3, 1'b1, 1'b0, 1'b1);
    check("after_halt_run", 32'(bus.valid_out), 32'd1);

    cur_instr = 32'h0; cur_valid = 1'b0; halt_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!m_stall) begin
        cur_instr = rand_instr();
        cur_valid = ($urandom_range(0, 9) != 0);
      end
      cur_flush = !m_draining && !m_halted && ($urandom_range(0, 9) == 0);
      halt_cnt  = m_halted ? halt_cnt + 1 : 0;
      cur_rst   = ($urandom_range(0, 199) != 0) && (halt_cnt <= 4);
      applyStimulus(cur_instr, cur_valid, cur_flush, cur_rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
